// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: strip timing at 100 MHz, driver state encoding and GRB colour constants.
package ws2812_pkg;

   localparam int LED_BITS = 24;

   localparam int T0H    = 35;
   localparam int T1H    = 70;
   localparam int TBIT   = 125;
   localparam int TRESET = 5000;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      LATCH
   } state_t;

   // Colours are packed G[23:16], R[15:8], B[7:0] to match the strip's wire order
   localparam logic [LED_BITS-1:0] OFF    = 24'h000000;
   localparam logic [LED_BITS-1:0] RED    = 24'h00FF00;
   localparam logic [LED_BITS-1:0] ORANGE = 24'h80FF00;
   localparam logic [LED_BITS-1:0] GREEN  = 24'hFF0000;
   localparam logic [LED_BITS-1:0] CYAN   = 24'hFF00FF;
   localparam logic [LED_BITS-1:0] BLUE   = 24'h0000FF;
   localparam logic [LED_BITS-1:0] VIOLET = 24'h0080FF;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Combinational WS2812 pulse shaper: line level for a given bit value at a given position in the bit period.
module ws2812_bit_encoder
   import ws2812_pkg::*;
#(
   parameter int TW    = 13,
   parameter int HIGH0 = T0H,
   parameter int HIGH1 = T1H
) (
   input  logic [TW-1:0] timer,
   input  logic          bit_val,
   output logic          level
);

   assign level = timer < (bit_val ? TW'(HIGH1) : TW'(HIGH0));

endmodule

// File: rtl/ws2812_frame_driver.sv
// Serialises a latched GRB frame onto the WS2812 data line, MSB first, then holds the line low for the latch time.
//
// state | meaning
// IDLE  | line low, waiting for Start
// SEND  | shifting out frame bits, one TBIT period each
// LATCH | line held low for TRESET clocks, then Done
module ws2812_frame_driver
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 5,
   parameter int T0H      = ws2812_pkg::T0H,
   parameter int T1H      = ws2812_pkg::T1H,
   parameter int TBIT     = ws2812_pkg::TBIT,
   parameter int TRESET   = ws2812_pkg::TRESET
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_LEDS*LED_BITS-1:0] GRBin,
   input  logic                         Start,
   output logic                         DataOut,
   output logic                         Busy,
   output logic                         Done
);

   localparam int FW = NUM_LEDS * LED_BITS;
   localparam int TW = $clog2((TBIT > TRESET) ? TBIT : TRESET);
   localparam int IW = $clog2(FW);

   state_t          state;
   logic [FW-1:0]   shift;
   logic [IW-1:0]   bit_idx;
   logic [TW-1:0]   timer;

   logic            wrap_bit;
   logic            last_bit;
   logic [TW-1:0]   enc_timer;
   logic            enc_bit;
   logic            enc_level;

   // The encoder looks one clock ahead so the registered line lines up with the timer
   assign wrap_bit  = (timer == TW'(TBIT - 1));
   assign last_bit  = (bit_idx == IW'(FW - 1));
   assign enc_timer = wrap_bit ? '0 : timer + TW'(1);
   assign enc_bit   = wrap_bit ? shift[FW-2] : shift[FW-1];

   ws2812_bit_encoder #(
      .TW    (TW),
      .HIGH0 (T0H),
      .HIGH1 (T1H)
   ) u_bit_encoder (
      .timer   (enc_timer),
      .bit_val (enc_bit),
      .level   (enc_level)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         shift   <= '0;
         bit_idx <= '0;
         timer   <= '0;
         DataOut <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               DataOut <= 1'b0;
               Busy    <= 1'b0;
               if (Start) begin
                  shift   <= GRBin;
                  timer   <= '0;
                  bit_idx <= '0;
                  // Every bit opens with a high phase, so the first level is known
                  DataOut <= 1'b1;
                  Busy    <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (wrap_bit) begin
                  timer <= '0;
                  shift <= {shift[FW-2:0], 1'b0};
                  if (last_bit) begin
                     DataOut <= 1'b0;
                     state   <= LATCH;
                  end else begin
                     bit_idx <= bit_idx + IW'(1);
                     DataOut <= enc_level;
                  end
               end else begin
                  timer   <= timer + TW'(1);
                  DataOut <= enc_level;
               end
            end
            LATCH: begin
               DataOut <= 1'b0;
               if (timer == TW'(TRESET - 1)) begin
                  timer <= '0;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench for ws2812_frame_driver with shortened timing so whole frames stay cheap to simulate.
module tb_ws2812_frame_driver;

   localparam int NL     = 5;
   localparam int FW     = NL * 24;
   localparam int P_T0H  = 3;
   localparam int P_T1H  = 7;
   localparam int P_TBIT = 10;
   localparam int P_TRST = 37;
   localparam int L      = FW * P_TBIT + P_TRST;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          Start = 1'b0;
   logic [FW-1:0] GRBin = '0;
   logic          DataOut;
   logic          Busy;
   logic          Done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ws2812_frame_driver #(
      .NUM_LEDS (NL),
      .T0H      (P_T0H),
      .T1H      (P_T1H),
      .TBIT     (P_TBIT),
      .TRESET   (P_TRST)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .GRBin   (GRBin),
      .Start   (Start),
      .DataOut (DataOut),
      .Busy    (Busy),
      .Done    (Done)
   );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a frame at the next edge and follows it cycle by cycle up to the Done cycle.
   task automatic run_frame(input logic [FW-1:0] frame, input bit hold, input bit isolate,
                            output logic [FW-1:0] decoded, output int wave_errs,
                            output int ctrl_errs, output int done_at, output logic first_dout);
      int   hc;
      int   b;
      int   t;
      logic exp_d;
      GRBin      = frame;
      Start      = 1'b1;
      wave_errs  = 0;
      ctrl_errs  = 0;
      done_at    = -1;
      decoded    = '0;
      hc         = 0;
      first_dout = 1'b0;
      for (int k = 1; k <= L + 1; k++) begin
         @(negedge clk);
         if (!hold && k == 1) Start = 1'b0;
         if (k == 1) first_dout = DataOut;
         if (k <= FW * P_TBIT) begin
            b     = (k - 1) / P_TBIT;
            t     = (k - 1) % P_TBIT;
            exp_d = (t < (frame[FW-1-b] ? P_T1H : P_T0H));
            if (DataOut === 1'b1) hc++;
            if (t == P_TBIT - 1) begin
               decoded[FW-1-b] = (hc > (P_T0H + P_T1H) / 2);
               hc = 0;
            end
         end else begin
            exp_d = 1'b0;
         end
         if (DataOut !== exp_d) wave_errs++;
         if (k <= L) begin
            if (Busy !== 1'b1 || Done !== 1'b0) ctrl_errs++;
         end else if (Busy !== 1'b0) begin
            ctrl_errs++;
         end
         if (Done === 1'b1 && done_at < 0) done_at = k;
         if (isolate && k == 60 * P_TBIT + 1) begin
            GRBin = ~frame;
            Start = 1'b1;
         end
         if (isolate && k == 60 * P_TBIT + 2) Start = 1'b0;
      end
   endtask

   task automatic idle_tail(input string tag);
      int nd;
      int nb;
      nd = 0;
      nb = 0;
      repeat (6) begin
         @(negedge clk);
         if (Done === 1'b1) nd++;
         if (Busy === 1'b1) nb++;
      end
      check_eq({tag, "_extra_done"}, nd, 0);
      check_eq({tag, "_idle_busy"}, nb, 0);
   endtask

   task automatic frame_checks(input string tag, input logic [FW-1:0] exp_frame,
                               input logic [FW-1:0] decoded, input int wave_errs,
                               input int ctrl_errs, input int done_at);
      check_eq({tag, "_wave"}, wave_errs, 0);
      check_eq({tag, "_busy_done"}, ctrl_errs, 0);
      check_eq({tag, "_decoded"}, decoded, exp_frame);
      check_eq({tag, "_done_at"}, done_at, L + 1);
   endtask

   initial begin
      logic [FW-1:0] dec;
      logic [FW-1:0] fa;
      logic [FW-1:0] fb;
      logic [FW-1:0] fz;
      int            we;
      int            ce;
      int            da;
      logic          fd;
      int            nd;
      int            d1;
      int            d2;

      fa = 120'h0123456789ABCDEF0123456789ABCD;
      fb = 120'hFEDCBA9876543210FEDCBA98765432;
      fz = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_dataout", DataOut, 1'b0);
      check_eq("rst_busy", Busy, 1'b0);
      check_eq("rst_done", Done, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_busy", Busy, 1'b0);

      // Reset mid-frame during bit 37
      GRBin = fa;
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      check_eq("start_first_high", DataOut, 1'b1);
      check_eq("start_busy", Busy, 1'b1);
      repeat (37 * P_TBIT) @(negedge clk);
      check_eq("bit37_high", DataOut, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_eq("abort_dataout", DataOut, 1'b0);
      check_eq("abort_busy", Busy, 1'b0);
      nd = 0;
      repeat (L + 10) begin
         @(negedge clk);
         if (Done === 1'b1) nd++;
      end
      check_eq("abort_no_done", nd, 0);
      check_eq("abort_stays_idle", Busy, 1'b0);
      run_frame(fa, 1'b0, 1'b0, dec, we, ce, da, fd);
      frame_checks("after_abort", fa, dec, we, ce, da);
      idle_tail("after_abort");

      // Single LED of ones
      run_frame({24'hFFFFFF, 96'h0}, 1'b0, 1'b0, dec, we, ce, da, fd);
      frame_checks("one_led", {24'hFFFFFF, 96'h0}, dec, we, ce, da);
      idle_tail("one_led");

      // Byte order: red on LED0
      run_frame({24'h00FF00, 96'h0}, 1'b0, 1'b0, dec, we, ce, da, fd);
      check_eq("order_wave", we, 0);
      check_eq("order_g", dec[FW-1 -: 8], 8'h00);
      check_eq("order_r", dec[FW-9 -: 8], 8'hFF);
      check_eq("order_rest", dec[FW-17:0], 104'h0);
      idle_tail("order");

      // Input isolation: GRBin change and Start pulse at bit 60
      run_frame(fb, 1'b0, 1'b1, dec, we, ce, da, fd);
      frame_checks("isolate", fb, dec, we, ce, da);
      idle_tail("isolate");

      // Back-to-back with Start held high
      run_frame(fa, 1'b1, 1'b0, dec, we, ce, da, fd);
      frame_checks("b2b_first", fa, dec, we, ce, da);
      d1 = cyc;
      run_frame(fb, 1'b1, 1'b0, dec, we, ce, da, fd);
      d2 = cyc;
      Start = 1'b0;
      frame_checks("b2b_second", fb, dec, we, ce, da);
      check_eq("b2b_rise_after_done", fd, 1'b1);
      check_eq("b2b_done_gap", d2 - d1, L + 1);
      idle_tail("b2b");

      // All-zero frame
      run_frame(fz, 1'b0, 1'b0, dec, we, ce, da, fd);
      frame_checks("zero", fz, dec, we, ce, da);
      idle_tail("zero");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ws2812_frame_driver.md
# ws2812_frame_driver

Serialises the 120-bit GRB frame produced by the game engine (five LEDs × 24 bits) onto the single-wire WS2812 LED strip. It latches a frame on a start request and emits each bit as a timed high/low pulse, MSB first. It then holds the line low for the reset/latch interval and reports completion. It sits directly downstream of the game engine's `GRBout` and drives the board's LED data pin.

## Interface

**Parameters**
- `NUM_LEDS`, default 5: LEDs per frame. Frame width is `NUM_LEDS*24`.
- `T0H`, default 35: clocks the line is high for a `0` bit.
- `T1H`, default 70: clocks the line is high for a `1` bit.
- `TBIT`, default 125: total clocks per bit (1.25 µs at 100 MHz).
- `TRESET`, default 5000: clocks the line is held low after the last bit (50 µs).

**Ports**
- `clk`, in, 1: sole clock, rising-edge.
- `reset`, in, 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `GRBin`, in, `NUM_LEDS*24`: frame to display. Bits [119:96] are LED0. The GRB byte order is G[23:16], R[15:8], B[7:0].
- `Start`, in, 1: frame request. Sampled only in IDLE.
- `DataOut`, out, 1: strip data line. Registered.
- `Busy`, out, 1: high from the cycle after `Start` is accepted until frame end.
- `Done`, out, 1: one-cycle pulse when the latch interval completes.

## Operation

- States: IDLE, SEND, LATCH.
- **Reset:**
  - State goes to IDLE.
  - `DataOut=0`, `Busy=0`, `Done=0`.
  - Shift register, bit index and timer are all cleared.
  - A reset in mid-frame aborts immediately: the line drops low and no `Done` is produced.
- **IDLE:**
  - `DataOut=0`, `Busy=0`.
  - If `Start=1`: capture `GRBin` into the shift register, clear the timer, set the bit index to 0, and go to SEND.
  - If `Start=0`: stay in IDLE.
- **SEND:**
  - Current bit = `shift[MSB]`.
  - `DataOut=1` while `timer < (bit ? T1H : T0H)`, otherwise `DataOut=0`.
  - Timer counts 0..`TBIT-1`. On `TBIT-1`:
    - Shift left by 1 and increment the bit index.
    - Clear the timer.
    - If the index was `NUM_LEDS*24-1`, go to LATCH.
- **LATCH:**
  - `DataOut=0`. Timer counts 0..`TRESET-1`.
  - On `TRESET-1`: go to IDLE and pulse `Done` for one cycle.
- **Input isolation:** changes to `GRBin` during SEND or LATCH have no effect. The captured frame is sent unchanged.
- **Start outside IDLE:** `Start` asserted during SEND or LATCH is ignored and not queued.
- **Back-to-back frames:** if `Start` is held high continuously, a new frame begins on the cycle after `Done`, since IDLE lasts exactly one cycle.
- **Timer width:** `$clog2(max(TBIT,TRESET))`, shared by SEND and LATCH.
- **Bit-index width:** `$clog2(NUM_LEDS*24)`. The index never wraps past the last bit.

## Timing

- **Start to first bit:** `Start` sampled high at edge E. At E+1, `DataOut=1` and `Busy=1`. `DataOut` is registered, so each waveform transition lands one clock after the state/timer condition.
- **Pulse shapes:**
  - Bit `1`: high for `T1H` clocks, then low for `TBIT-T1H`.
  - Bit `0`: high for `T0H` clocks, then low for `TBIT-T0H`.
- **Frame length:** from E+1 to the `Done` cycle is `NUM_LEDS*24*TBIT + TRESET` clocks. With defaults that is 15000 + 5000 = 20000.
- **End of frame:** `Busy` falls in the same cycle that `Done` is high.
- **Throughput:** the next `Start` can be accepted in the `Done` cycle at the earliest.

## Structure

- **Package `ws2812_pkg`, shared with the game engine:**
  - Timing constants `T0H`, `T1H`, `TBIT`, `TRESET`.
  - State encoding enum (IDLE/SEND/LATCH).
  - GRB colour constants OFF, RED, ORANGE, GREEN, CYAN, BLUE, VIOLET.
  - `LED_BITS=24`.
- **Sub-module `ws2812_bit_encoder`:** takes the timer and current bit and produces the high/low level. It is purely combinational; the parent registers the output.
- **Top-level logic:** the FSM, shift register, bit index and timer live in `ws2812_frame_driver`.

## Test plan

1. **Reset mid-frame:** assert `reset=0` during bit 37 → next cycle `DataOut=0`, `Busy=0`. No `Done` appears; the next `Start` sends a full frame from bit 0.
2. **Single LED 1-bits:** `GRBin = {24'hFFFFFF, 96'h0}`, pulse `Start` → 24 pulses with 70 high / 55 low, then 96 pulses with 35 high / 90 low. Then 5000 low clocks, then a `Done` pulse at clock 20000 after E+1.
3. **Byte order:** `GRBin = {24'h00FF00, 96'h0}` (RED on LED0) → bits 0–7 are 0, bits 8–15 are 1, bits 16–119 are 0.
4. **Input isolation:** change `GRBin` and pulse `Start` at bit 60 → the waveform matches the originally captured frame, and there is exactly one `Done`.
5. **Back-to-back:** hold `Start=1` → consecutive `Done` pulses are exactly 20001 clocks apart, and `DataOut` rises one cycle after each `Done`.
6. **Zero frame:** `GRBin = 0` → 120 pulses of 35 high, with `Busy` high throughout and `DataOut` never high during LATCH.
